reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_seq_pkg.sv | 24 ++
 rtl/sync_debounce.sv | 46 ++++
 rtl/reset_sequencer.sv | 166 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared state encoding, default parameter values and counter sizing
// for the staged reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT    = 2'd0,
        ST_RELEASE   = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_t;

    localparam int DEF_NUM_STAGES      = 3;
    localparam int DEF_SYNC_DEPTH      = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_STAGE_GAP       = 4;
    localparam int DEF_DONE_STAGE      = 1;
    localparam int DEF_TIMEOUT_CYCLES  = 1024;

    // Bits needed for a counter that must be able to hold 'limit'.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Multi-flop synchronizer followed by a press qualifier: one o_press pulse once
// the synced input has been high for DEBOUNCE_CYCLES consecutive cycles.
module sync_debounce
    import reset_seq_pkg::*;
#(
    parameter int SYNC_DEPTH      = DEF_SYNC_DEPTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_press
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_FIRE = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_DEPTH-1:0] r_sync;
    logic [CW-1:0]         r_cnt;
    logic                  r_press;
    logic                  w_sync;

    assign w_sync = r_sync[SYNC_DEPTH-1];

    // Counter parks at CNT_MAX while held high, so only one pulse per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_DEPTH-2:0], i_async};
            r_press <= w_sync && (r_cnt == CNT_FIRE);
            if (!w_sync)
                r_cnt <= '0;
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_sync  = w_sync;
    assign o_press = r_press;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: rst_out bits drop one at a time, STAGE_GAP apart, once PLL lock
// is stable. Optional init_done watchdog is enabled by defining RESET_SEQ_WATCHDOG_EN.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES      = DEF_NUM_STAGES,
    parameter int SYNC_DEPTH      = DEF_SYNC_DEPTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int STAGE_GAP       = DEF_STAGE_GAP,
    parameter int DONE_STAGE      = DEF_DONE_STAGE,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_in,
    input  logic                  pll_lock,
    input  logic                  init_done,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  seq_busy,
    output logic                  timeout_flag
);

    localparam int                    GW       = cnt_width(STAGE_GAP);
    localparam logic [GW-1:0]         GAP_MAX  = GW'(STAGE_GAP);
    localparam logic [GW-1:0]         GAP_FIRE = GW'(STAGE_GAP - 1);
    localparam int                    IW       = cnt_width(NUM_STAGES);
    localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_STAGES - 1);
    localparam logic [IW-1:0]         DONE_IDX = IW'(DONE_STAGE);
    localparam bit                    WAIT_EN  = (DONE_STAGE < NUM_STAGES);
    localparam logic [NUM_STAGES-1:0] ONE_LSB  = NUM_STAGES'(1);

    if (NUM_STAGES < 1 || NUM_STAGES > 8 || SYNC_DEPTH < 2 || SYNC_DEPTH > 4 ||
        DEBOUNCE_CYCLES < 1 || STAGE_GAP < 1 || DONE_STAGE < 0 || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("reset_sequencer: parameter out of range");
    end

    seq_state_t            r_state, next_state;
    logic [IW-1:0]         r_idx, next_idx;
    logic [GW-1:0]         r_gap, next_gap;
    logic [NUM_STAGES-1:0] r_rst, next_rst;
    logic                  r_busy;
    logic                  r_done_ok, next_done_ok;
    logic [SYNC_DEPTH-1:0] r_lock_sync;
    logic                  w_lock;
    logic                  w_press;
    logic                  w_release;

    sync_debounce #(
        .SYNC_DEPTH      (SYNC_DEPTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (btn_in),
        .o_sync  (),
        .o_press (w_press)
    );

    assign w_lock = r_lock_sync[SYNC_DEPTH-1];

`ifdef RESET_SEQ_WATCHDOG_EN
    localparam int            WW      = cnt_width(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WD_FIRE = WW'(TIMEOUT_CYCLES - 1);
    logic [WW-1:0] r_wd, next_wd;
    logic          r_flag, next_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd   <= '0;
            r_flag <= 1'b0;
        end else begin
            r_wd   <= next_wd;
            r_flag <= next_flag;
        end
    end

    assign timeout_flag = r_flag;
`else
    assign timeout_flag = 1'b0;
`endif

    // r_done_ok marks that init_done has already released the gated stage this pass.
    always_comb begin
        next_state   = r_state;
        next_idx     = r_idx;
        next_gap     = r_gap;
        next_rst     = r_rst;
        next_done_ok = r_done_ok;
        w_release    = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
        next_wd      = '0;
        next_flag    = r_flag;
`endif
        if (w_press || !w_lock) begin
            next_state   = ST_ASSERT;
            next_idx     = '0;
            next_gap     = '0;
            next_rst     = '1;
            next_done_ok = 1'b0;
        end else begin
            case (r_state)
                ST_ASSERT, ST_RELEASE: begin
                    if (r_gap == GAP_FIRE) begin
                        next_gap = '0;
                        if (WAIT_EN && (r_idx == DONE_IDX) && !r_done_ok && !init_done)
                            next_state = ST_WAIT_DONE;
                        else
                            w_release = 1'b1;
                    end else if (r_gap != GAP_MAX) begin
                        next_gap = r_gap + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (init_done) begin
                        next_state   = ST_RELEASE;
                        next_gap     = '0;
                        next_done_ok = 1'b1;
                    end
`ifdef RESET_SEQ_WATCHDOG_EN
                    else if (r_wd == WD_FIRE) begin
                        next_flag  = 1'b1;
                        next_state = ST_ASSERT;
                        next_idx   = '0;
                        next_rst   = '1;
                    end else begin
                        next_wd = r_wd + 1'b1;
                    end
`endif
                end
                ST_RUN: begin
                end
                default: next_state = ST_ASSERT;
            endcase

            if (w_release) begin
                next_rst   = r_rst & ~(ONE_LSB << r_idx);
                next_idx   = r_idx + 1'b1;
                next_state = (r_idx == LAST_IDX) ? ST_RUN : ST_RELEASE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ASSERT;
            r_idx       <= '0;
            r_gap       <= '0;
            r_rst       <= '1;
            r_busy      <= 1'b1;
            r_done_ok   <= 1'b0;
            r_lock_sync <= '0;
        end else begin
            r_state     <= next_state;
            r_idx       <= next_idx;
            r_gap       <= next_gap;
            r_rst       <= next_rst;
            r_busy      <= |next_rst;
            r_done_ok   <= next_done_ok;
            r_lock_sync <= {r_lock_sync[SYNC_DEPTH-2:0], pll_lock};
        end
    end

    assign rst_out  = r_rst;
    assign seq_busy = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters; the watchdog
// scenario follows RESET_SEQ_WATCHDOG_EN.
module tb_reset_sequencer;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       btn_in    = 1'b0;
    logic       pll_lock  = 1'b0;
    logic       init_done = 1'b0;
    logic [2:0] rst_out;
    logic       seq_busy;
    logic       timeout_flag;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    reset_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_in       (btn_in),
        .pll_lock     (pll_lock),
        .init_done    (init_done),
        .rst_out      (rst_out),
        .seq_busy     (seq_busy),
        .timeout_flag (timeout_flag)
    );

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int n);
        while (cyc < n) step();
    endtask

    // Cycle 1 is the first rising edge after rst_n is released.
    task automatic start(input logic lock, input logic done);
        rst_n     = 1'b0;
        btn_in    = 1'b0;
        pll_lock  = lock;
        init_done = done;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pll_lock = 1'b1; init_done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL reset_rst_out: got %b want 111", rst_out); end
        total++; if (seq_busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", seq_busy); end
        total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL reset_flag: got %b want 0", timeout_flag); end
    endtask

    task automatic test_power_up();
        start(1'b1, 1'b1);
        step_to(6);
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL pwr_c6: got %b want 111", rst_out); end
        step_to(7);
        total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL pwr_c7: got %b want 110", rst_out); end
        step_to(10);
        total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL pwr_c10: got %b want 110", rst_out); end
        step_to(11);
        total++; if (rst_out !== 3'b100) begin bad++; $display("FAIL pwr_c11: got %b want 100", rst_out); end
        step_to(14);
        total++; if (rst_out !== 3'b100) begin bad++; $display("FAIL pwr_c14: got %b want 100", rst_out); end
        total++; if (seq_busy !== 1'b1) begin bad++; $display("FAIL pwr_busy_c14: got %b want 1", seq_busy); end
        step_to(15);
        total++; if (rst_out !== 3'b000) begin bad++; $display("FAIL pwr_c15: got %b want 000", rst_out); end
        total++; if (seq_busy !== 1'b0) begin bad++; $display("FAIL pwr_busy_c15: got %b want 0", seq_busy); end
    endtask

    task automatic test_button();
        logic [2:0] exp;
        step_to(20);
        btn_in = 1'b1;
        repeat (10) step();
        btn_in = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            total++; if (rst_out !== 3'b000) begin bad++; $display("FAIL btn_short_%0d: got %b want 000", i, rst_out); end
        end
        btn_in = 1'b1;
        for (int b = 1; b <= 32; b++) begin
            step();
            if (b == 20) btn_in = 1'b0;
            if (b == 19 || b == 20 || b == 23 || b == 24 || b == 28 || b == 32) begin
                case (b)
                    19:      exp = 3'b000;
                    20, 23:  exp = 3'b111;
                    24:      exp = 3'b110;
                    28:      exp = 3'b100;
                    default: exp = 3'b000;
                endcase
                total++; if (rst_out !== exp) begin bad++; $display("FAIL btn_long_b%0d: got %b want %b", b, rst_out, exp); end
            end
        end
        repeat (40) step();
        total++; if (rst_out !== 3'b000) begin bad++; $display("FAIL btn_once: got %b want 000", rst_out); end
        total++; if (seq_busy !== 1'b0) begin bad++; $display("FAIL btn_busy: got %b want 0", seq_busy); end
    endtask

    task automatic test_lock_drop();
        start(1'b1, 1'b1);
        step_to(8);
        total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL lock_c8: got %b want 110", rst_out); end
        pll_lock = 1'b0;
        step_to(11);
        total++; if (rst_out !== 3'b100) begin bad++; $display("FAIL lock_c11: got %b want 100", rst_out); end
        step_to(12);
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL lock_c12: got %b want 111", rst_out); end
        total++; if (seq_busy !== 1'b1) begin bad++; $display("FAIL lock_busy_c12: got %b want 1", seq_busy); end
        step_to(17);
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL lock_c17: got %b want 111", rst_out); end
        pll_lock = 1'b1;
        step_to(23);
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL lock_c23: got %b want 111", rst_out); end
        step_to(24);
        total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL lock_c24: got %b want 110", rst_out); end
    endtask

    task automatic test_wait_done();
        start(1'b1, 1'b0);
        step_to(11);
        total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL wd_c11: got %b want 110", rst_out); end
        step_to(39);
        total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL wd_c39: got %b want 110", rst_out); end
        total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL wd_flag_c39: got %b want 0", timeout_flag); end
        init_done = 1'b1;
        step_to(43);
        total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL wd_c43: got %b want 110", rst_out); end
        step_to(44);
        total++; if (rst_out !== 3'b100) begin bad++; $display("FAIL wd_c44: got %b want 100", rst_out); end
        step_to(47);
        total++; if (rst_out !== 3'b100) begin bad++; $display("FAIL wd_c47: got %b want 100", rst_out); end
        step_to(48);
        total++; if (rst_out !== 3'b000) begin bad++; $display("FAIL wd_c48: got %b want 000", rst_out); end
        total++; if (seq_busy !== 1'b0) begin bad++; $display("FAIL wd_busy_c48: got %b want 0", seq_busy); end
    endtask

    task automatic test_async_reset();
        start(1'b1, 1'b1);
        step_to(12);
        total++; if (rst_out !== 3'b100) begin bad++; $display("FAIL arst_c12: got %b want 100", rst_out); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL arst_rst_out: got %b want 111", rst_out); end
        total++; if (seq_busy !== 1'b1) begin bad++; $display("FAIL arst_busy: got %b want 1", seq_busy); end
        total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL arst_flag: got %b want 0", timeout_flag); end
        repeat (2) @(posedge clk);
        #1;
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL arst_hold: got %b want 111", rst_out); end
    endtask

    task automatic test_watchdog();
        start(1'b1, 1'b0);
`ifdef RESET_SEQ_WATCHDOG_EN
        step_to(1034);
        total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL wdog_flag_c1034: got %b want 0", timeout_flag); end
        total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL wdog_c1034: got %b want 110", rst_out); end
        step_to(1035);
        total++; if (timeout_flag !== 1'b1) begin bad++; $display("FAIL wdog_flag_c1035: got %b want 1", timeout_flag); end
        total++; if (rst_out !== 3'b111) begin bad++; $display("FAIL wdog_c1035: got %b want 111", rst_out); end
        step_to(1060);
        total++; if (timeout_flag !== 1'b1) begin bad++; $display("FAIL wdog_sticky: got %b want 1", timeout_flag); end
        rst_n = 1'b0;
        #1;
        total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL wdog_clear: got %b want 0", timeout_flag); end
`else
        step_to(1100);
        total++; if (timeout_flag !== 1'b0) begin bad++; $display("FAIL nowdog_flag: got %b want 0", timeout_flag); end
        total++; if (rst_out !== 3'b110) begin bad++; $display("FAIL nowdog_hold: got %b want 110", rst_out); end
`endif
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_button();
        test_lock_drop();
        test_wait_done();
        test_async_reset();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
